// File: rtl/arm_cpu_pkg.sv
// ==== arm_cpu_pkg : shared types/constants for the LDM/STM sequencer ====
// ==== Revision 1.0                                                      ====
`default_nettype none

package arm_cpu_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_AW     = 4;
  localparam int NREGS      = 16;
  localparam int WORD_BYTES = 4;

  // Encoded as {UP, PRE}
  localparam logic [1:0] AM_DA = 2'b00;
  localparam logic [1:0] AM_DB = 2'b01;
  localparam logic [1:0] AM_IA = 2'b10;
  localparam logic [1:0] AM_IB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/reg_list_penc.sv
// ==== reg_list_penc : lowest-set-bit priority encoder over the register list ====
// ==== Revision 1.0                                                           ====
`default_nettype none

module reg_list_penc
  import arm_cpu_pkg::*;
(
  input  logic [NREGS-1:0]  i_mask,
  output logic [REG_AW-1:0] o_idx,
  output logic              o_valid
);

  // Descending scan so the lowest set bit is the last (winning) assignment.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx   = REG_AW'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ldm_stm_seq.sv
// ==== ldm_stm_seq : ARM LDM/STM multi-register sequencer (option: LDM_STM_ABORT_EN) ====
// ==== Revision 1.0                                                                  ====
`default_nettype none

module ldm_stm_seq #(
  parameter int DATA_W = arm_cpu_pkg::WORD_W,
  parameter int REG_AW = arm_cpu_pkg::REG_AW
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 IS_LOAD,
  input  logic                 UP,
  input  logic                 PRE,
  input  logic                 WBACK,
  input  logic [REG_AW-1:0]    BASE_REG,
  input  logic [DATA_W-1:0]    BASE_ADDR,
  input  logic [2**REG_AW-1:0] REG_LIST,
  output logic [DATA_W-1:0]    MEM_ADDR,
  output logic                 MEM_RE,
  output logic                 MEM_WE,
  output logic [DATA_W-1:0]    MEM_WDATA,
  input  logic [DATA_W-1:0]    MEM_RDATA,
  input  logic                 MEM_READY,
`ifdef LDM_STM_ABORT_EN
  input  logic                 MEM_ABORT,
  output logic                 ABORT,
`endif
  output logic [REG_AW-1:0]    RF_RADDR,
  input  logic [DATA_W-1:0]    RF_RDATA,
  output logic [REG_AW-1:0]    RF_WADDR,
  output logic [DATA_W-1:0]    RF_WDATA,
  output logic                 RF_W_EN,
  output logic                 BUSY,
  output logic                 DONE
);

  import arm_cpu_pkg::*;

  localparam int NR = 2**REG_AW;
  localparam int CW = REG_AW + 1;

  seq_state_e        r_state;
  logic              r_is_load;
  logic              r_do_wb;
  logic [REG_AW-1:0] r_base_reg;
  logic [NR-1:0]     r_pending;
  logic [DATA_W-1:0] r_final;
  logic [DATA_W-1:0] r_addr;
  logic              r_re;
  logic              r_we;
  logic              r_busy;
  logic              r_done;
`ifdef LDM_STM_ABORT_EN
  logic              r_abort;
`endif

  logic [CW-1:0]     w_cnt;
  logic [DATA_W-1:0] w_span;
  logic [DATA_W-1:0] w_start;
  logic [DATA_W-1:0] w_final;
  logic [REG_AW-1:0] w_cur;
  logic              w_cur_vld;
  logic              w_xfer;
  logic              w_abort;
  logic              w_beat;
  logic              w_last;

  reg_list_penc u_penc (
    .i_mask  (r_pending),
    .o_idx   (w_cur),
    .o_valid (w_cur_vld)
  );

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NR; i++) begin
      w_cnt = w_cnt + CW'(REG_LIST[i]);
    end
  end

  assign w_span  = DATA_W'(w_cnt) << 2;
  assign w_final = UP ? (BASE_ADDR + w_span) : (BASE_ADDR - w_span);

  // Every mode walks upward; decrement modes just start lower.
  always_comb begin
    case ({UP, PRE})
      AM_IA:   w_start = BASE_ADDR;
      AM_IB:   w_start = BASE_ADDR + DATA_W'(WORD_BYTES);
      AM_DA:   w_start = BASE_ADDR - w_span + DATA_W'(WORD_BYTES);
      default: w_start = BASE_ADDR - w_span;
    endcase
  end

  assign w_xfer = (r_state == ST_XFER) && w_cur_vld;
`ifdef LDM_STM_ABORT_EN
  assign w_abort = w_xfer && MEM_ABORT;
`else
  assign w_abort = 1'b0;
`endif
  assign w_beat = w_xfer && MEM_READY && !w_abort;
  assign w_last = (r_pending & (r_pending - NR'(1))) == '0;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_is_load  <= 1'b0;
      r_do_wb    <= 1'b0;
      r_base_reg <= '0;
      r_pending  <= '0;
      r_final    <= '0;
      r_addr     <= '0;
      r_re       <= 1'b0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef LDM_STM_ABORT_EN
      r_abort    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef LDM_STM_ABORT_EN
      r_abort <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_is_load  <= IS_LOAD;
            r_base_reg <= BASE_REG;
            r_pending  <= REG_LIST;
            r_final    <= w_final;
            // A loaded base must not be overwritten by the final address.
            r_do_wb    <= WBACK && !(IS_LOAD && REG_LIST[BASE_REG]);
            r_busy     <= 1'b1;
            if (REG_LIST != '0) begin
              r_state <= ST_XFER;
              r_addr  <= w_start;
              r_re    <= IS_LOAD;
              r_we    <= !IS_LOAD;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_XFER: begin
          if (w_abort) begin
            r_state <= ST_DONE;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
`ifdef LDM_STM_ABORT_EN
            r_abort <= 1'b1;
`endif
          end else if (w_beat) begin
            r_pending <= r_pending & ~(NR'(1) << w_cur);
            r_addr    <= r_addr + DATA_W'(WORD_BYTES);
            if (w_last) begin
              r_re   <= 1'b0;
              r_we   <= 1'b0;
              r_addr <= '0;
              if (r_do_wb) begin
                r_state <= ST_WB;
              end else begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        ST_WB: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_ADDR  = r_addr;
  assign MEM_RE    = r_re;
  assign MEM_WE    = r_we;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
`ifdef LDM_STM_ABORT_EN
  assign ABORT     = r_abort;
`endif
  assign RF_RADDR  = w_xfer ? w_cur : '0;
  assign MEM_WDATA = (w_xfer && !r_is_load) ? RF_RDATA : '0;

  always_comb begin
    RF_W_EN  = 1'b0;
    RF_WADDR = '0;
    RF_WDATA = '0;
    if (w_beat && r_is_load) begin
      RF_W_EN  = 1'b1;
      RF_WADDR = w_cur;
      RF_WDATA = MEM_RDATA;
    end else if (r_state == ST_WB) begin
      RF_W_EN  = 1'b1;
      RF_WADDR = r_base_reg;
      RF_WDATA = r_final;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ldm_stm_seq.sv
// ==== tb_ldm_stm_seq : scoreboard bench for ldm_stm_seq ====
// ==== Revision 1.0                                       ====
`default_nettype none

module tb_ldm_stm_seq;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } mem_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } rf_t;

  logic        CLK = 1'b0;
  logic        RST, START, IS_LOAD, UP, PRE, WBACK, MEM_READY;
  logic [3:0]  BASE_REG;
  logic [31:0] BASE_ADDR;
  logic [15:0] REG_LIST;
  wire  [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA, RF_RDATA, RF_WDATA;
  wire         MEM_RE, MEM_WE, RF_W_EN, BUSY, DONE;
  wire  [3:0]  RF_RADDR, RF_WADDR;

  int   n_chk  = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  mem_t mem_q[$];
  rf_t  rf_q[$];

  always #5 CLK = ~CLK;

  // Environment: memory returns D000_<addr[15:0]>, register Rn reads CAFE_000n.
  assign MEM_RDATA = {16'hD000, MEM_ADDR[15:0]};
  assign RF_RDATA  = {16'hCAFE, 12'h000, RF_RADDR};

  ldm_stm_seq dut (
    .CLK(CLK), .RST(RST), .START(START), .IS_LOAD(IS_LOAD), .UP(UP), .PRE(PRE),
    .WBACK(WBACK), .BASE_REG(BASE_REG), .BASE_ADDR(BASE_ADDR), .REG_LIST(REG_LIST),
    .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY), .RF_RADDR(RF_RADDR),
    .RF_RDATA(RF_RDATA), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA),
    .RF_W_EN(RF_W_EN), .BUSY(BUSY), .DONE(DONE)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_mem(input logic [31:0] a, input logic we, input logic [31:0] d);
    mem_t e;
    e.addr = a; e.we = we; e.data = d;
    mem_q.push_back(e);
  endtask

  task automatic exp_rf(input logic [3:0] a, input logic [31:0] d);
    rf_t e;
    e.addr = a; e.data = d;
    rf_q.push_back(e);
  endtask

  // Monitor: pops and compares whenever the DUT completes an access or an RF write.
  always @(negedge CLK) begin
    if (mon_en) begin
      if ((MEM_RE || MEM_WE) && MEM_READY) begin
        if (mem_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL mem_unexpected: got access at %h, expected none", MEM_ADDR);
        end else begin
          mem_t e;
          e = mem_q.pop_front();
          chk("mem_addr", MEM_ADDR, e.addr);
          chk("mem_we", {31'b0, MEM_WE}, {31'b0, e.we});
          chk("mem_re", {31'b0, MEM_RE}, {31'b0, !e.we});
          if (e.we) chk("mem_wdata", MEM_WDATA, e.data);
        end
      end
      if (RF_W_EN) begin
        if (rf_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rf_unexpected: got write R%0d=%h, expected none", RF_WADDR, RF_WDATA);
        end else begin
          rf_t e;
          e = rf_q.pop_front();
          chk("rf_waddr", {28'b0, RF_WADDR}, {28'b0, e.addr});
          chk("rf_wdata", RF_WDATA, e.data);
        end
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_addr"}, MEM_ADDR, 32'h0);
    chk({nm, "_wdata"}, MEM_WDATA, 32'h0);
    chk({nm, "_ctl"}, {26'b0, MEM_RE, MEM_WE, RF_W_EN, BUSY, DONE, 1'b0}, 32'h0);
    chk({nm, "_rf"}, {RF_RADDR, RF_WADDR, 24'b0}, 32'h0);
    chk({nm, "_rfwdata"}, RF_WDATA, 32'h0);
  endtask

  task automatic start_op(input logic ld, input logic up, input logic pre, input logic wb,
                          input logic [3:0] br, input logic [31:0] ba,
                          input logic [15:0] rl, input logic rdy);
    IS_LOAD = ld; UP = up; PRE = pre; WBACK = wb;
    BASE_REG = br; BASE_ADDR = ba; REG_LIST = rl; MEM_READY = rdy;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat, input int first_cyc);
    int cyc;
    bit seen;
    cyc  = first_cyc;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
      else begin
        cyc++;
        @(posedge CLK); #1;
      end
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got no DONE, expected DONE at cycle %0d", nm, exp_lat);
    end else begin
      chk({nm, "_latency"}, cyc, exp_lat);
      chk({nm, "_busy_done"}, {31'b0, BUSY}, 32'd1);
      @(posedge CLK); #1;
      chk({nm, "_idle"}, {30'b0, BUSY, DONE}, 32'd0);
    end
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; IS_LOAD = 1'b0; UP = 1'b0; PRE = 1'b0; WBACK = 1'b0;
    BASE_REG = '0; BASE_ADDR = '0; REG_LIST = '0; MEM_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    RST = 1'b1;
    mon_en = 1'b1;

    // STM IA: R1@0x100, R2@0x104
    exp_mem(32'h100, 1'b1, 32'hCAFE_0001);
    exp_mem(32'h104, 1'b1, 32'hCAFE_0002);
    start_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h100, 16'h0006, 1'b1);
    wait_done("stm_ia", 3, 1);

    // LDM IB WBACK R13: R0<-[0x204], R15<-[0x208], R13<-0x208
    exp_mem(32'h204, 1'b0, 32'h0);
    exp_mem(32'h208, 1'b0, 32'h0);
    exp_rf(4'd0,  32'hD000_0204);
    exp_rf(4'd15, 32'hD000_0208);
    exp_rf(4'd13, 32'h0000_0208);
    start_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd13, 32'h200, 16'h8001, 1'b1);
    wait_done("ldm_ib_wb", 4, 1);

    // STM DB WBACK R13: R4..R7 @0x2F0..0x2FC, R13<-0x2F0
    exp_mem(32'h2F0, 1'b1, 32'hCAFE_0004);
    exp_mem(32'h2F4, 1'b1, 32'hCAFE_0005);
    exp_mem(32'h2F8, 1'b1, 32'hCAFE_0006);
    exp_mem(32'h2FC, 1'b1, 32'hCAFE_0007);
    exp_rf(4'd13, 32'h0000_02F0);
    start_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h300, 16'h00F0, 1'b1);
    wait_done("stm_db_wb", 6, 1);

    // LDM base in list: R2<-[0x500], writeback suppressed
    exp_mem(32'h500, 1'b0, 32'h0);
    exp_rf(4'd2, 32'hD000_0500);
    start_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h500, 16'h0004, 1'b1);
    wait_done("ldm_base_in_list", 2, 1);

    // STM DA single reg, WBACK R1: R3@0x600, R1<-0x5FC
    exp_mem(32'h600, 1'b1, 32'hCAFE_0003);
    exp_rf(4'd1, 32'h0000_05FC);
    start_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h600, 16'h0008, 1'b1);
    wait_done("stm_da_n1", 3, 1);

    // STM base in list: original R0 stored, then R0<-0x704
    exp_mem(32'h700, 1'b1, 32'hCAFE_0000);
    exp_rf(4'd0, 32'h0000_0704);
    start_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h700, 16'h0001, 1'b1);
    wait_done("stm_base_in_list", 3, 1);

    // Address wrap: LDM IA from 0xFFFFFFFC, R5<-0x4
    exp_mem(32'hFFFF_FFFC, 1'b0, 32'h0);
    exp_mem(32'h0000_0000, 1'b0, 32'h0);
    exp_rf(4'd0, 32'hD000_FFFC);
    exp_rf(4'd1, 32'hD000_0000);
    exp_rf(4'd5, 32'h0000_0004);
    start_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 32'hFFFF_FFFC, 16'h0003, 1'b1);
    wait_done("ldm_wrap", 4, 1);

    // Wait states on first beat, plus a START while busy that must be ignored
    exp_mem(32'h400, 1'b0, 32'h0);
    exp_mem(32'h404, 1'b0, 32'h0);
    exp_rf(4'd0, 32'hD000_0400);
    exp_rf(4'd1, 32'hD000_0404);
    start_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h400, 16'h0003, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      if (k == 2) begin
        START = 1'b1;
        REG_LIST = 16'hFFFF;
      end
      @(negedge CLK);
      chk("stall_addr", MEM_ADDR, 32'h400);
      chk("stall_ctl", {29'b0, MEM_RE, MEM_WE, RF_W_EN}, 32'b100);
      @(posedge CLK); #1;
      START = 1'b0;
    end
    MEM_READY = 1'b1;
    wait_done("stall", 6, 4);

    // Empty list: DONE next cycle, no access
    start_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h800, 16'h0000, 1'b1);
    wait_done("empty", 1, 1);

    // Reset mid-transfer
    mon_en = 1'b0;
    start_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h900, 16'h00FF, 1'b0);
    @(negedge CLK);
    chk("midrst_pre", {30'b0, MEM_RE, BUSY}, 32'b11);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    chk_all_zero("midrst");
    mon_en = 1'b1;

    chk("mem_q_empty", mem_q.size(), 32'd0);
    chk("rf_q_empty", rf_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
